// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA timing generator. A pixel strobe is derived from CLK by
// integer division (PX_DIV CLKs per pixel). Horizontal and vertical counters
// advance on each pixel strobe. Sync, blanking and coordinate outputs are
// registered and change on the same edge as the counters.
//
// Ports:
//   CLK         system clock
//   RST_N       asynchronous active-low reset
//   en          run enable; low freezes divider, counters and outputs
//   px_stb      one-CLK pixel strobe (combinational from registered divider)
//   x, y        current column / line counters
//   active      high inside the visible area
//   hsync       horizontal sync, asserted level = HS_POL
//   vsync       vertical sync, asserted level = VS_POL
//   line_start  one-CLK pulse at column 0 of every line
//   frame_start one-CLK pulse at column 0 of line 0
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PX_DIV   = 1,
  parameter int CW       = 10
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          en,
  output logic          px_stb,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (PX_DIV > 1) ? $clog2(PX_DIV) : 1;

  // Reject geometries the counters cannot represent and a zero divider.
  if (PX_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: PX_DIV must be >= 1");
  end
  if (((H_TOTAL - 1) >> CW) != 0) begin : g_bad_h
    $error("vga_timing_gen: H_TOTAL-1 does not fit in CW bits");
  end
  if (((V_TOTAL - 1) >> CW) != 0) begin : g_bad_v
    $error("vga_timing_gen: V_TOTAL-1 does not fit in CW bits");
  end

  localparam logic [DW-1:0] DIV_MAX = DW'(PX_DIV - 1);
  localparam logic [CW-1:0] H_MAX   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);

  // Sync window bounds carry one extra bit: the end of the sync pulse may
  // equal the total when the back porch is zero.
  localparam logic [CW:0] HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  logic          active_q, active_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;

  // RST_N gating keeps the strobes quiet while reset is held, even with
  // PX_DIV=1 where the divider decode alone would follow en.
  assign px_stb      = RST_N && en && (div_cnt_q == DIV_MAX);
  assign line_start  = px_stb && (hc_q == '0);
  assign frame_start = line_start && (vc_q == '0);

  assign x      = hc_q;
  assign y      = vc_q;
  assign active = active_q;
  assign hsync  = hsync_q;
  assign vsync  = vsync_q;

  always_comb begin
    div_cnt_d = div_cnt_q;
    hc_d      = hc_q;
    vc_d      = vc_q;
    active_d  = active_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;

    if (en) begin
      div_cnt_d = (div_cnt_q == DIV_MAX) ? '0 : div_cnt_q + DW'(1);
    end

    if (px_stb) begin
      if (hc_q == H_MAX) begin
        hc_d = '0;
        vc_d = (vc_q == V_MAX) ? '0 : vc_q + CW'(1);
      end else begin
        hc_d = hc_q + CW'(1);
      end
      // Decoded from the next counter values so the registered outputs
      // line up with x/y in the same cycle.
      active_d = (hc_d < H_ACT) && (vc_d < V_ACT);
      hsync_d  = (({1'b0, hc_d} >= HS_BEG) && ({1'b0, hc_d} < HS_END)) ? HS_ON : ~HS_ON;
      vsync_d  = (({1'b0, vc_d} >= VS_BEG) && ({1'b0, vc_d} < VS_END)) ? VS_ON : ~VS_ON;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt_q <= '0;
      hc_q      <= '0;
      vc_q      <= '0;
      active_q  <= 1'b1;
      hsync_q   <= ~HS_ON;
      vsync_q   <= ~VS_ON;
    end else begin
      div_cnt_q <= div_cnt_d;
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      active_q  <= active_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

endmodule
